// File: rtl/sport_sclk_fs_gen.sv
// SPORT0 internal SCLK and frame-sync generator: divides DSPCLK into SCLK, emits edge strobes and TFS/RFS pulses.
// Optional macro SPORT_FSCNT_RD_EN exposes the frame counter on FSCNT_do for the DMD read bus.
module sport_sclk_fs_gen #(
    parameter int CW     = 16,
    parameter int FS_LEN = 1
) (
    input  logic          DSPCLK,
    input  logic          RST,
    input  logic          SPEN,
    input  logic          ISCLK,
    input  logic          INVxSCLK,
    input  logic          ITFS,
    input  logic          IRFS,
    input  logic [1:0]    FSD,
    input  logic [CW-1:0] SCLKDIV,
    input  logic [CW-1:0] FSDIV,
    input  logic          TX_RDY,
    input  logic          RX_RDY,
    output logic          SCLK_o,
    output logic          SCLK_R,
    output logic          SCLK_F,
    output logic          TFS_o,
    output logic          RFS_o
`ifdef SPORT_FSCNT_RD_EN
    ,
    input  logic          selFSCNT,
    output logic [CW-1:0] FSCNT_do
`endif
);

    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [1:0]    LEN_LOAD = 2'(FS_LEN - 1);

    typedef enum logic {FS_IDLE, FS_ACTIVE} fs_state_t;

    logic          run;
    logic          load_pend_reg;
    logic [CW-1:0] half_cnt_reg;
    logic [CW-1:0] half_eff;
    logic          sclk_int_reg;
    logic          sclk_r_reg;
    logic          sclk_f_reg;
    logic [CW-1:0] fcnt_reg;
    logic [CW-1:0] fsdiv_reg;
    logic [CW-1:0] fsdiv_eff;
    logic          tog;
    logic          rise;
    logic          fall;
    logic          frame_tc;
    logic [1:0]    ixfs;
    logic [1:0]    rdy;
    logic [1:0]    fs_out;

    assign run = SPEN & ISCLK;

    // A pending load makes the first running cycle behave as if SCLKDIV had just been loaded.
    assign half_eff  = load_pend_reg ? SCLKDIV : half_cnt_reg;
    assign fsdiv_eff = load_pend_reg ? FSDIV : fsdiv_reg;
    assign tog       = run & (half_eff == '0);
    assign rise      = tog & ~sclk_int_reg;
    assign fall      = tog & sclk_int_reg;
    assign frame_tc  = rise & (fcnt_reg == fsdiv_eff);

    always_ff @(posedge DSPCLK or posedge RST) begin
        if (RST) begin
            load_pend_reg <= 1'b1;
            half_cnt_reg  <= '0;
            sclk_int_reg  <= 1'b0;
            sclk_r_reg    <= 1'b0;
            sclk_f_reg    <= 1'b0;
            fcnt_reg      <= '0;
            fsdiv_reg     <= '0;
        end else if (!run) begin
            load_pend_reg <= 1'b1;
            half_cnt_reg  <= '0;
            sclk_int_reg  <= 1'b0;
            sclk_r_reg    <= 1'b0;
            sclk_f_reg    <= 1'b0;
            fcnt_reg      <= '0;
            fsdiv_reg     <= '0;
        end else begin
            load_pend_reg <= 1'b0;
            sclk_r_reg    <= rise;
            sclk_f_reg    <= fall;
            fsdiv_reg     <= fsdiv_eff;
            if (tog) begin
                sclk_int_reg <= ~sclk_int_reg;
                half_cnt_reg <= SCLKDIV;
            end else begin
                half_cnt_reg <= half_eff - CNT_ONE;
            end
            // New FSDIV is only picked up when the frame wraps.
            if (frame_tc) begin
                fcnt_reg  <= '0;
                fsdiv_reg <= FSDIV;
            end else if (rise) begin
                fcnt_reg <= fcnt_reg + CNT_ONE;
            end
        end
    end

    assign ixfs = {IRFS, ITFS};
    assign rdy  = {RX_RDY, TX_RDY};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_fs
            fs_state_t  state_reg, state_next;
            logic [1:0] len_reg, len_next;
            logic       trig;

            assign trig = frame_tc & ixfs[gi] & (~FSD[gi] | rdy[gi]);

            always_ff @(posedge DSPCLK or posedge RST) begin
                if (RST) begin
                    state_reg <= FS_IDLE;
                    len_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    len_reg   <= len_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                len_next   = len_reg;
                if (!run || !ixfs[gi]) begin
                    state_next = FS_IDLE;
                    len_next   = '0;
                end else begin
                    case (state_reg)
                        FS_IDLE: begin
                            if (trig) begin
                                state_next = FS_ACTIVE;
                                len_next   = LEN_LOAD;
                            end
                        end
                        FS_ACTIVE: begin
                            // A frame boundary inside a pulse restarts the width count.
                            if (trig) begin
                                len_next = LEN_LOAD;
                            end else if (rise) begin
                                if (len_reg == 2'd0) begin
                                    state_next = FS_IDLE;
                                end else begin
                                    len_next = len_reg - 2'd1;
                                end
                            end
                        end
                        default: begin
                            state_next = FS_IDLE;
                            len_next   = '0;
                        end
                    endcase
                end
            end

            assign fs_out[gi] = (state_reg == FS_ACTIVE);
        end
    endgenerate

    assign SCLK_o = sclk_int_reg ^ INVxSCLK;
    assign SCLK_R = sclk_r_reg;
    assign SCLK_F = sclk_f_reg;
    assign TFS_o  = fs_out[0];
    assign RFS_o  = fs_out[1];

`ifdef SPORT_FSCNT_RD_EN
    assign FSCNT_do = {CW{selFSCNT}} & fcnt_reg;
`endif

endmodule

// File: tb/tb_sport_sclk_fs_gen.sv
// Self-checking bench for sport_sclk_fs_gen: cycle-level behavioural model plus hand-computed literal checkpoints.
module tb_sport_sclk_fs_gen;
    localparam int CW     = 16;
    localparam int FS_LEN = 1;

    logic          DSPCLK = 1'b0;
    logic          RST, SPEN, ISCLK, INVxSCLK, ITFS, IRFS, TX_RDY, RX_RDY;
    logic [1:0]    FSD;
    logic [CW-1:0] SCLKDIV, FSDIV;
    logic          SCLK_o, SCLK_R, SCLK_F, TFS_o, RFS_o;
`ifdef SPORT_FSCNT_RD_EN
    logic          selFSCNT = 1'b1;
    logic [CW-1:0] FSCNT_do;
`endif

    sport_sclk_fs_gen #(.CW(CW), .FS_LEN(FS_LEN)) dut (
        .DSPCLK(DSPCLK), .RST(RST), .SPEN(SPEN), .ISCLK(ISCLK), .INVxSCLK(INVxSCLK),
        .ITFS(ITFS), .IRFS(IRFS), .FSD(FSD), .SCLKDIV(SCLKDIV), .FSDIV(FSDIV),
        .TX_RDY(TX_RDY), .RX_RDY(RX_RDY), .SCLK_o(SCLK_o), .SCLK_R(SCLK_R),
        .SCLK_F(SCLK_F), .TFS_o(TFS_o), .RFS_o(RFS_o)
`ifdef SPORT_FSCNT_RD_EN
        , .selFSCNT(selFSCNT), .FSCNT_do(FSCNT_do)
`endif
    );

    always #5 DSPCLK = ~DSPCLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: time since the last SCLK toggle, current half-period length,
    // number of SCLK rises since the generator started, and per-direction pulse end.
    bit m_on;
    int m_since, m_plen, m_rises;
    bit m_lvl, m_r, m_f;
    bit m_fs [2];
    int m_fs_end [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_since = 0; m_plen = 1; m_rises = 0;
        m_lvl = 0; m_r = 0; m_f = 0;
        m_fs[0] = 0; m_fs[1] = 0;
        m_fs_end[0] = 0; m_fs_end[1] = 0;
    endtask

    task automatic model_edge();
        bit tc;
        bit [1:0] ix, rd;
        if (RST || !(SPEN && ISCLK)) begin
            model_reset();
        end else begin
            if (!m_on) begin
                m_on = 1; m_since = 0; m_plen = int'(SCLKDIV) + 1;
            end
            m_since++;
            m_r = 0; m_f = 0; tc = 0;
            if (m_since == m_plen) begin
                m_lvl = !m_lvl; m_r = m_lvl; m_f = !m_lvl;
                m_since = 0; m_plen = int'(SCLKDIV) + 1;
            end
            if (m_r) begin
                m_rises++;
                tc = (m_rises % (int'(FSDIV) + 1)) == 0;
            end
            ix = {IRFS, ITFS};
            rd = {RX_RDY, TX_RDY};
            for (int d = 0; d < 2; d++) begin
                if (!ix[d]) m_fs[d] = 0;
                else if (m_r) begin
                    if (tc && (!FSD[d] || rd[d])) begin
                        m_fs[d] = 1; m_fs_end[d] = m_rises + FS_LEN;
                    end else if (m_fs[d] && m_rises == m_fs_end[d]) begin
                        m_fs[d] = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("SCLK_o", 32'(SCLK_o), 32'(m_lvl ^ INVxSCLK));
        chk("SCLK_R", 32'(SCLK_R), 32'(m_r));
        chk("SCLK_F", 32'(SCLK_F), 32'(m_f));
        chk("TFS_o",  32'(TFS_o),  32'(m_fs[0]));
        chk("RFS_o",  32'(RFS_o),  32'(m_fs[1]));
`ifdef SPORT_FSCNT_RD_EN
        chk("FSCNT_do", 32'(FSCNT_do), 32'(m_rises % (int'(FSDIV) + 1)));
`endif
    endtask

    task automatic step();
        @(posedge DSPCLK);
        model_edge();
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic go(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic restart();
        SPEN = 1'b0;
        go(2);
        SPEN = 1'b1;
        cyc = 0;
    endtask

    initial begin
        RST = 1'b1; SPEN = 1'b0; ISCLK = 1'b1; INVxSCLK = 1'b0;
        ITFS = 1'b1; IRFS = 1'b1; TX_RDY = 1'b0; RX_RDY = 1'b0; FSD = 2'b00;
        SCLKDIV = 16'd3; FSDIV = 16'd7;
        model_reset();
        #1;
        chk("reset SCLK_o", 32'(SCLK_o), 32'd0);
        chk("reset TFS_o", 32'(TFS_o), 32'd0);
        go(3);
        RST = 1'b0;
        go(2);

        // Divider 3, frame 8: SCLK period 8 DSPCLK, TFS once every 8 SCLK periods.
        SPEN = 1'b1; cyc = 0;
        go(3);  chk("A no edge before cyc4", 32'(SCLK_R), 32'd0);
        go(1);  chk("A first SCLK_R cyc4", 32'(SCLK_R), 32'd1);
        go(4);  chk("A SCLK_F cyc8", 32'(SCLK_F), 32'd1);
        go(4);  chk("A SCLK_R cyc12", 32'(SCLK_R), 32'd1);
        go(47); chk("A TFS low cyc59", 32'(TFS_o), 32'd0);
        go(1);  chk("A TFS high cyc60", 32'(TFS_o), 32'd1);
        go(7);  chk("A TFS high cyc67", 32'(TFS_o), 32'd1);
        go(1);  chk("A TFS low cyc68", 32'(TFS_o), 32'd0);
        go(56); chk("A TFS again cyc124", 32'(TFS_o), 32'd1);

        // External SCLK freezes everything; divider 0 toggles every DSPCLK.
        ISCLK = 1'b0;
        go(2);  chk("B ISCLK=0 SCLK_R", 32'(SCLK_R), 32'd0);
        SCLKDIV = 16'd0; FSDIV = 16'd3; ISCLK = 1'b1; cyc = 0;
        go(1);  chk("B div0 SCLK_R cyc1", 32'(SCLK_R), 32'd1);
        go(1);  chk("B div0 SCLK_F cyc2", 32'(SCLK_F), 32'd1);
        go(20);
        FSDIV = 16'd0;
        restart();
        go(6);  chk("B FSDIV=0 TFS stretched", 32'(TFS_o), 32'd1);

        // Demand framing: TFS waits for TX_RDY, RFS has RX_RDY.
        SCLKDIV = 16'd1; FSDIV = 16'd3; FSD = 2'b11; TX_RDY = 1'b0; RX_RDY = 1'b1;
        restart();
        go(14); chk("C TFS skipped cyc14", 32'(TFS_o), 32'd0);
                chk("C RFS cyc14", 32'(RFS_o), 32'd1);
        go(6);  TX_RDY = 1'b1;
        go(10); chk("C TFS cyc30", 32'(TFS_o), 32'd1);

        // Divider change mid half-period only applies from the next reload.
        SCLKDIV = 16'd3; FSDIV = 16'd7; FSD = 2'b00;
        restart();
        go(6);  SCLKDIV = 16'd1;
        go(1);  chk("D no SCLK_F cyc7", 32'(SCLK_F), 32'd0);
        go(1);  chk("D SCLK_F cyc8", 32'(SCLK_F), 32'd1);
        go(1);  chk("D no SCLK_R cyc9", 32'(SCLK_R), 32'd0);
        go(1);  chk("D SCLK_R cyc10", 32'(SCLK_R), 32'd1);
        go(8);

        // Disable during a pulse, then restart from frame count 0.
        SCLKDIV = 16'd1; FSDIV = 16'd1; INVxSCLK = 1'b1;
        restart();
        go(6);  chk("E TFS cyc6", 32'(TFS_o), 32'd1);
        go(2);  SPEN = 1'b0;
        go(1);  chk("E disable TFS", 32'(TFS_o), 32'd0);
                chk("E disable SCLK_o", 32'(SCLK_o), 32'd1);
        go(1);  SPEN = 1'b1; cyc = 0;
        go(11); SPEN = 1'b0;
        go(2);  SPEN = 1'b1; cyc = 0;
        go(2);  chk("E restart no TFS cyc2", 32'(TFS_o), 32'd0);
        go(4);  chk("E restart TFS cyc6", 32'(TFS_o), 32'd1);
        ITFS = 1'b0;
        go(1);  chk("F ITFS off TFS", 32'(TFS_o), 32'd0);
                chk("F RFS still high", 32'(RFS_o), 32'd1);

        // Asynchronous reset mid-frame with inverted SCLK.
        #3;
        RST = 1'b1;
        #1;
        model_reset();
        chk("G async SCLK_o", 32'(SCLK_o), 32'd1);
        chk("G async RFS_o", 32'(RFS_o), 32'd0);
        chk("G async TFS_o", 32'(TFS_o), 32'd0);
`ifdef SPORT_FSCNT_RD_EN
        chk("G async FSCNT_do", 32'(FSCNT_do), 32'd0);
`endif
        go(2);
        RST = 1'b0; ITFS = 1'b1; cyc = 0;
        go(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
